// File: rtl/efpga_fifo_pkg.sv
// Shared types and helpers for the efpga_fifo_sync controller and its storage.
package efpga_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } rd_state_e;

  // Pointers carry one extra wrap bit above the array address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/efpga_fifo_mem.sv
// FIFO storage: write port on wclk, read address latched on rclk when re, async read of latched address.
module efpga_fifo_mem
  import efpga_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             wclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rclk,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    raddr_q;

  always_ff @(posedge wclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Holding the address keeps rdata stable while the output stage is stalled.
  always_ff @(posedge rclk) begin
    if (re) raddr_q <= raddr;
  end

  assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/efpga_fifo_sync.sv
// Single-clock FIFO with prefetching read FSM and registered FWFT output stage.
// Optional sticky overflow flag built only when EFPGA_FIFO_OVF_EN is defined.
module efpga_fifo_sync
  import efpga_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  rd_state_e        state_q, state_d;
  logic [PW-1:0]    wptr_q, rptr_q, count_q;
  logic             vld_q;
  logic [WIDTH-1:0] data_q, rdata;
  logic             arr_empty, push_acc, pop, xfer, ren;

  assign arr_empty = (wptr_q == rptr_q);
  assign full_o    = (count_q == PW'(DEPTH));
  assign push_acc  = push_i && !full_o && !clr_i;
  assign pop       = vld_q && out_ready_i;
  assign xfer      = (state_q == FETCH) && (!vld_q || pop) && !clr_i;
  assign ren       = !arr_empty && ((state_q == IDLE) || xfer) && !clr_i;

  efpga_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .wclk  (clk_i),
    .we    (push_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (push_data_i),
    .rclk  (clk_i),
    .re    (ren),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ren)  state_d = FETCH;
        FETCH:   if (xfer) state_d = ren ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clr_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        vld_q   <= 1'b0;
      end else begin
        if (push_acc) wptr_q <= wptr_q + PW'(1);
        if (ren)      rptr_q <= rptr_q + PW'(1);
        count_q <= count_q + PW'(push_acc) - PW'(pop);
        if (xfer) begin
          vld_q  <= 1'b1;
          data_q <= rdata;
        end else if (pop) begin
          vld_q  <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o   = vld_q;
  assign out_data_o    = data_q;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= AF_T);

`ifdef EFPGA_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               ovf_q <= 1'b0;
    else if (clr_i)            ovf_q <= 1'b0;
    else if (push_i && full_o) ovf_q <= 1'b1;
  end

  assign overflow_o = ovf_q;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !clr_i));
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_efpga_fifo_sync.sv
// Scoreboard bench for efpga_fifo_sync: reference queue + occupancy model, directed and random phases.
module tb_efpga_fifo_sync;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   clr_i = 1'b0;
  logic                   push_i = 1'b0;
  logic [WIDTH-1:0]       push_data_i = '0;
  logic                   full_o, almost_full_o, out_valid_o, overflow_o;
  logic                   out_ready_i = 1'b0;
  logic [WIDTH-1:0]       out_data_o;
  logic [$clog2(DEPTH):0] count_o;

  efpga_fifo_sync #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (clr_i),
    .push_i        (push_i),
    .push_data_i   (push_data_i),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int         npass = 0;
  int         ntot  = 0;
  logic [31:0] sb[$];
  int         mcount = 0;
  logic       movf = 1'b0;
  logic       last_pop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock: drive inputs, update the reference model, then check the
  // registered flags one step after the edge.
  task automatic cyc(input logic p, input logic [31:0] d, input logic r, input logic c);
    logic pop_now, acc;
    logic [31:0] e;
    push_i = p; push_data_i = d; out_ready_i = r; clr_i = c;
    #1;
    pop_now  = out_valid_o && r;
    acc      = p && (mcount < DEPTH);
    last_pop = pop_now;
    if (pop_now) begin
      chk("pop_has_exp", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", out_data_o, e);
      end
    end
    if (c) begin
      sb.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      if (p && mcount == DEPTH) movf = 1'b1;
      if (acc) sb.push_back(d);
      mcount = mcount + int'(acc) - int'(pop_now);
    end
    @(posedge clk_i); #1;
    chk("count", count_o, mcount);
    chk("full", full_o, mcount == DEPTH);
    chk("afull", almost_full_o, mcount >= AF);
`ifdef EFPGA_FIFO_OVF_EN
    chk("ovf", overflow_o, movf);
`else
    chk("ovf", overflow_o, 0);
`endif
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      cyc(0, 0, 1, 0);
      n++;
    end
    chk({tag, "_empty"}, sb.size(), 0);
    chk({tag, "_vld"}, out_valid_o, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_vld", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_cnt", count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_af", almost_full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // First word: visible two edges after the push edge, then held while stalled
    cyc(1, 32'hA5A5_0001, 0, 0);
    chk("lat_e1", out_valid_o, 0);
    cyc(0, 0, 0, 0);
    chk("lat_e2", out_valid_o, 0);
    cyc(0, 0, 0, 0);
    chk("lat_vld", out_valid_o, 1);
    chk("lat_data", out_data_o, 32'hA5A5_0001);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      chk("hold_vld", out_valid_o, 1);
      chk("hold_data", out_data_o, 32'hA5A5_0001);
    end
    drain("first");

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 32'(i), 0, 0);
      if (i == 4) begin
        chk("fill_full", full_o, 1);
        chk("fill_cnt", count_o, 4);
      end
    end
`ifdef EFPGA_FIFO_OVF_EN
    chk("ovf_set", overflow_o, 1);
`endif
    drain("fill");
    cyc(0, 0, 0, 1);

    // Streaming: one pop per clock once the pipeline is primed; occupancy
    // settles at 3 (output register + prefetch + one word in the array).
    for (int i = 0; i < 64; i++) begin
      cyc(1, 32'h100 + 32'(i), 1, 0);
      if (i >= 3) chk("stream_rate", last_pop, 1);
      chk("stream_cnt", 32'(count_o <= 3), 1);
    end
    drain("stream");

    // Random push/backpressure
    begin
      int pushes = 0;
      int n = 0;
      while (pushes < 500 && n < 5000) begin
        logic p;
        p = ($urandom_range(0, 99) < 60);
        if (p) pushes++;
        cyc(p, $urandom, ($urandom_range(0, 99) < 50), 0);
        n++;
      end
      chk("rand_pushes", pushes, 500);
    end
    drain("rand");

    // Wrap-around: push only alongside a pop so occupancy stays at 2
    cyc(1, 32'h200, 0, 0);
    cyc(1, 32'h201, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wrap_pre", count_o, 2);
    for (int i = 0; i < 20; i++) begin
      cyc(out_valid_o, 32'h300 + 32'(i), 1, 0);
      chk("wrap_cnt", count_o, 2);
    end
    drain("wrap");

    // Flush with a concurrent push and pop
    cyc(1, 32'h400, 0, 0);
    cyc(1, 32'h401, 0, 0);
    cyc(1, 32'h402, 0, 0);
    cyc(0, 0, 0, 0);
    chk("flush_pre_cnt", count_o, 3);
    chk("flush_pre_vld", out_valid_o, 1);
    cyc(1, 32'hDEAD_BEEF, 1, 1);
    chk("flush_cnt", count_o, 0);
    chk("flush_vld", out_valid_o, 0);
    chk("flush_ovf", overflow_o, 0);
    cyc(1, 32'h500, 0, 0);
    drain("flush");

    // Reset mid-operation discards everything
    cyc(1, 32'h600, 0, 0);
    cyc(1, 32'h601, 0, 0);
    cyc(0, 0, 0, 0);
    rst_ni = 1'b0;
    #2;
    chk("arst_vld", out_valid_o, 0);
    chk("arst_cnt", count_o, 0);
    rst_ni = 1'b1;
    sb.delete();
    mcount = 0;
    movf   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      chk("arst_novld", out_valid_o, 0);
    end
    cyc(1, 32'h700, 1, 0);
    drain("arst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", ntot, 0);
    $fatal(1);
  end

endmodule
